// File: rtl/cu_cbfp_blk.sv
// +--------------------------------------------------------------------------+
// | Module   : cu_cbfp_blk                                                     |
// | Brief    : Control unit for one CBFP normalisation stage. Counts butterfly |
// |            samples into blocks of BLK_LEN and pipelines a {valid, first,   |
// |            last} tag to the magnitude, min-search and output stages.       |
// | Options  : CU_CBFP_BLKCNT_EN - adds the completed-block counter blk_cnt.  |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module cu_cbfp_blk #(
  parameter int BLK_LEN = 16,
  parameter int MAG_DLY = 1,
  parameter int MIN_DLY = 1,
  parameter int OUT_DLY = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             alert_cbfp,
  output logic             mag_en,
  output logic             mag_first,
  output logic             mag_last,
  output logic             min_en,
  output logic             min_last,
  output logic             valid_mod1,
  output logic             out_first,
  output logic             out_last
`ifdef CU_CBFP_BLKCNT_EN
  ,
  output logic [CNT_W-1:0] blk_cnt
`endif
);

  // Sample counter width; a one-sample block still needs a 1-bit register.
  localparam int                C_CW   = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;
  localparam logic [C_CW-1:0]   C_LAST = C_CW'(BLK_LEN - 1);

  // Tag bit positions inside every delay-line entry.
  localparam int C_V = 2;
  localparam int C_F = 1;
  localparam int C_L = 0;

  // flush behaves exactly like rst, and also drops a coincident sample.
  logic            w_clr;
  logic            w_take;
  logic [C_CW-1:0] r_cnt;
  logic            w_first;
  logic            w_last;
  logic [2:0]      w_tag_in;

  logic [2:0] r_mag_dl [MAG_DLY];
  logic [2:0] r_min_dl [MIN_DLY];
  logic [2:0] r_out_dl [OUT_DLY];

  logic [2:0] w_mag_tag;
  logic [2:0] w_min_tag;
  logic [2:0] w_out_tag;

  assign w_clr   = rst | flush;
  assign w_take  = alert_cbfp & ~w_clr;
  assign w_first = (r_cnt == '0);
  assign w_last  = (r_cnt == C_LAST);

  // Position tags are only ever set alongside valid, so every downstream
  // first/last is inherently zero whenever its stage enable is zero.
  assign w_tag_in = {w_take, w_take & w_first, w_take & w_last};

  // Position-in-block counter; advances only on accepted samples.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_cnt <= '0;
    end else if (alert_cbfp) begin
      if (w_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Stage 1 delay line: alert_cbfp to magnitude-detect enable.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      for (int i = 0; i < MAG_DLY; i++) begin
        r_mag_dl[i] <= '0;
      end
    end else begin
      r_mag_dl[0] <= w_tag_in;
      for (int i = 1; i < MAG_DLY; i++) begin
        r_mag_dl[i] <= r_mag_dl[i-1];
      end
    end
  end

  assign w_mag_tag = r_mag_dl[MAG_DLY-1];

  // Stage 2 delay line: magnitude stage to min-search enable.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      for (int i = 0; i < MIN_DLY; i++) begin
        r_min_dl[i] <= '0;
      end
    end else begin
      r_min_dl[0] <= w_mag_tag;
      for (int i = 1; i < MIN_DLY; i++) begin
        r_min_dl[i] <= r_min_dl[i-1];
      end
    end
  end

  assign w_min_tag = r_min_dl[MIN_DLY-1];

  // Stage 3 delay line: min-search stage to normalised output valid.
  // The first tag rides through stage 2 unexposed so out_first is available.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      for (int i = 0; i < OUT_DLY; i++) begin
        r_out_dl[i] <= '0;
      end
    end else begin
      r_out_dl[0] <= w_min_tag;
      for (int i = 1; i < OUT_DLY; i++) begin
        r_out_dl[i] <= r_out_dl[i-1];
      end
    end
  end

  assign w_out_tag = r_out_dl[OUT_DLY-1];

  // Every output is taken straight from the last flop of its delay line.
  assign mag_en     = w_mag_tag[C_V];
  assign mag_first  = w_mag_tag[C_F];
  assign mag_last   = w_mag_tag[C_L];
  assign min_en     = w_min_tag[C_V];
  assign min_last   = w_min_tag[C_L];
  assign valid_mod1 = w_out_tag[C_V];
  assign out_first  = w_out_tag[C_F];
  assign out_last   = w_out_tag[C_L];

`ifdef CU_CBFP_BLKCNT_EN
  logic [CNT_W-1:0] r_blk_cnt;

  // Completed-block counter; bumps the cycle after the last output sample.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_blk_cnt <= '0;
    end else if (valid_mod1 && out_last) begin
      r_blk_cnt <= r_blk_cnt + 1'b1;
    end
  end

  assign blk_cnt = r_blk_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cu_cbfp_blk.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_cu_cbfp_blk                                                  |
// | Brief    : Directed self-checking bench for cu_cbfp_blk. Instance A uses   |
// |            BLK_LEN=4 with default delays, instance B uses BLK_LEN=1 with   |
// |            delays 2/3/1. Optional blk_cnt checked when                     |
// |            CU_CBFP_BLKCNT_EN is defined.                                   |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_cu_cbfp_blk;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic alert_a;
  logic alert_b;

  logic a_mag_en, a_mag_first, a_mag_last, a_min_en, a_min_last;
  logic a_valid, a_out_first, a_out_last;
  logic b_mag_en, b_mag_first, b_mag_last, b_min_en, b_min_last;
  logic b_valid, b_out_first, b_out_last;
  logic [7:0] a_cnt;
  logic [7:0] b_cnt;

  logic [7:0] a_out;
  logic [7:0] b_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] pat;

  always #5 clk = ~clk;

  // Packed view: {mag_en, mag_first, mag_last, min_en, min_last, valid, first, last}
  assign a_out = {a_mag_en, a_mag_first, a_mag_last, a_min_en, a_min_last,
                  a_valid, a_out_first, a_out_last};
  assign b_out = {b_mag_en, b_mag_first, b_mag_last, b_min_en, b_min_last,
                  b_valid, b_out_first, b_out_last};

  cu_cbfp_blk #(
    .BLK_LEN (4),
    .MAG_DLY (1),
    .MIN_DLY (1),
    .OUT_DLY (2),
    .CNT_W   (8)
  ) u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .alert_cbfp (alert_a),
    .mag_en     (a_mag_en),
    .mag_first  (a_mag_first),
    .mag_last   (a_mag_last),
    .min_en     (a_min_en),
    .min_last   (a_min_last),
    .valid_mod1 (a_valid),
    .out_first  (a_out_first),
    .out_last   (a_out_last)
`ifdef CU_CBFP_BLKCNT_EN
    ,
    .blk_cnt    (a_cnt)
`endif
  );

  cu_cbfp_blk #(
    .BLK_LEN (1),
    .MAG_DLY (2),
    .MIN_DLY (3),
    .OUT_DLY (1),
    .CNT_W   (8)
  ) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .alert_cbfp (alert_b),
    .mag_en     (b_mag_en),
    .mag_first  (b_mag_first),
    .mag_last   (b_mag_last),
    .min_en     (b_min_en),
    .min_last   (b_min_last),
    .valid_mod1 (b_valid),
    .out_first  (b_out_first),
    .out_last   (b_out_last)
`ifdef CU_CBFP_BLKCNT_EN
    ,
    .blk_cnt    (b_cnt)
`endif
  );

`ifndef CU_CBFP_BLKCNT_EN
  assign a_cnt = '0;
  assign b_cnt = '0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int t, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Single pulse at t=10.
  function automatic logic [7:0] exp_single(input int t);
    case (t)
      11:      return 8'hC0;
      12:      return 8'h10;
      14:      return 8'h06;
      default: return 8'h00;
    endcase
  endfunction

  // Eight contiguous samples from t=0 (two full blocks).
  function automatic logic [7:0] exp_burst(input int t);
    case (t)
      1:       return 8'hC0;
      2, 3:    return 8'h90;
      4, 8:    return 8'hB6;
      5:       return 8'hDC;
      6:       return 8'h94;
      7:       return 8'h95;
      9:       return 8'h1C;
      10:      return 8'h04;
      11:      return 8'h05;
      default: return 8'h00;
    endcase
  endfunction

  // Gapped pattern 1,0,1,1,0,0,1.
  function automatic logic [7:0] exp_gap(input int t);
    case (t)
      1:       return 8'hC0;
      2, 5:    return 8'h10;
      3:       return 8'h80;
      4:       return 8'h96;
      6:       return 8'h04;
      7:       return 8'hA4;
      8:       return 8'h18;
      10:      return 8'h05;
      default: return 8'h00;
    endcase
  endfunction

  // Samples at t=0,1 kept, t=2 flushed, fresh sample at t=5.
  function automatic logic [7:0] exp_flush(input int t);
    case (t)
      1, 6:    return 8'hC0;
      2:       return 8'h90;
      7:       return 8'h10;
      9:       return 8'h06;
      default: return 8'h00;
    endcase
  endfunction

  // BLK_LEN=1, delays 2/3/1, three contiguous samples.
  function automatic logic [7:0] exp_b(input int t);
    case (t)
      2, 3, 4: return 8'hE0;
      5:       return 8'h18;
      6, 7:    return 8'h1F;
      8:       return 8'h07;
      default: return 8'h00;
    endcase
  endfunction

  initial begin
    rst     = 1'b1;
    flush   = 1'b0;
    alert_a = 1'b0;
    alert_b = 1'b0;
    pat     = 7'b1001101;

    tick();
    tick();
    chk("reset_a", 0, a_out, 8'h00);
    chk("reset_b", 0, b_out, 8'h00);
`ifdef CU_CBFP_BLKCNT_EN
    chk("reset_cnt_a", 0, a_cnt, 8'h00);
`endif
    rst = 1'b0;

    // Single pulse latency.
    for (int t = 0; t < 18; t++) begin
      alert_a = (t == 10);
      chk("single", t, a_out, exp_single(t));
      tick();
    end
    alert_a = 1'b0;

    // Two back-to-back blocks.
    do_reset();
    for (int t = 0; t < 14; t++) begin
      alert_a = (t < 8);
      chk("burst", t, a_out, exp_burst(t));
`ifdef CU_CBFP_BLKCNT_EN
      chk("burst_cnt", t, a_cnt, (t < 8) ? 8'd0 : ((t < 12) ? 8'd1 : 8'd2));
`endif
      tick();
    end

    // Reset with three samples in flight.
    for (int t = 0; t < 4; t++) begin
      alert_a = (t < 3);
      chk("inflight", t, a_out, (t == 0) ? 8'h00 : ((t == 1) ? 8'hC0 : 8'h90));
      if (t == 3) begin
        rst = 1'b1;
      end
      tick();
    end
    rst = 1'b0;
    for (int t = 4; t < 13; t++) begin
      chk("post_rst", t, a_out, 8'h00);
`ifdef CU_CBFP_BLKCNT_EN
      chk("post_rst_cnt", t, a_cnt, 8'h00);
`endif
      tick();
    end

    // Gapped input pattern.
    for (int t = 0; t < 14; t++) begin
      alert_a = (t < 7) ? pat[t] : 1'b0;
      chk("gap", t, a_out, exp_gap(t));
`ifdef CU_CBFP_BLKCNT_EN
      chk("gap_cnt", t, a_cnt, (t < 11) ? 8'd0 : 8'd1);
`endif
      tick();
    end
    alert_a = 1'b0;

    // Flush coincident with the third sample of a block.
    do_reset();
    for (int t = 0; t < 11; t++) begin
      alert_a = (t <= 2) || (t == 5);
      flush   = (t == 2);
      chk("flush", t, a_out, exp_flush(t));
`ifdef CU_CBFP_BLKCNT_EN
      chk("flush_cnt", t, a_cnt, 8'h00);
`endif
      tick();
    end
    alert_a = 1'b0;
    flush   = 1'b0;

    // One-sample blocks with unequal stage delays.
    do_reset();
    for (int t = 0; t < 11; t++) begin
      alert_b = (t < 3);
      chk("len1", t, b_out, exp_b(t));
`ifdef CU_CBFP_BLKCNT_EN
      chk("len1_cnt", t, b_cnt, (t < 7) ? 8'd0 : ((t < 9) ? 8'(t - 6) : 8'd3));
`endif
      tick();
    end
    alert_b = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cu_cbfp_blk.md
Name: cu_cbfp_blk

Overview:
- Parametrised control unit for one CBFP (convergent block floating point) normalisation stage.
- Takes the per-sample strobe from the preceding butterfly, alert_cbfp, and generates the enables for three datapath stages: magnitude detect, block-minimum search and normalised output.
- Groups samples into blocks of BLK_LEN and tags the first and last sample of each block at every stage, so the datapath knows when to reset, latch and apply the block exponent.
- Delays between stages are parameters. Gaps in alert_cbfp are allowed.

Parameters:
- BLK_LEN, 16: samples per CBFP block; legal range >= 1.
- MAG_DLY, 1: cycles from alert_cbfp to mag_en; legal range >= 1.
- MIN_DLY, 1: cycles from mag_en to min_en; legal range >= 1.
- OUT_DLY, 2: cycles from min_en to valid_mod1; legal range >= 1.
- CNT_W, 8: width of the completed-block counter (optional feature only).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline/counter clear; same effect as rst.
- alert_cbfp  in  1  one sample valid from the butterfly this cycle.
- mag_en  out  1  magnitude-detect stage enable.
- mag_first  out  1  qualifies mag_en: first sample of block.
- mag_last  out  1  qualifies mag_en: last sample of block.
- min_en  out  1  min-search stage enable.
- min_last  out  1  qualifies min_en: last sample; datapath latches block exponent.
- valid_mod1  out  1  normalised output sample valid.
- out_first  out  1  qualifies valid_mod1: first output sample of block.
- out_last  out  1  qualifies valid_mod1: last output sample of block.
- blk_cnt  out  CNT_W  completed output blocks (optional feature only).

Behaviour:
- Reset: rst high at a rising edge clears every output and all internal state to 0, including the sample counter, all delay-line bits and blk_cnt. Reset mid-block discards the partial block; the next alert_cbfp is a first sample.
- flush: identical clear to rst. If flush and alert_cbfp are both high in the same cycle, flush wins and the sample is dropped.
- Input sample counter:
  - Width clog2(BLK_LEN), minimum 1.
  - Advances only on alert_cbfp and wraps at BLK_LEN-1 back to 0.
  - first = (cnt==0); last = (cnt==BLK_LEN-1).
  - BLK_LEN=1: first and last are both 1 on every sample.
- Tag pipeline:
  - The triple {valid, first, last} travels through shift registers with no bubbles and no compression.
  - Stage 1, after MAG_DLY cycles: drives mag_en, mag_first, mag_last.
  - Stage 2, after a further MIN_DLY cycles: drives min_en and min_last.
  - Stage 3, after a further OUT_DLY cycles: drives valid_mod1, out_first, out_last.
- Latency: with defaults, an alert at cycle N gives mag_en at N+1, min_en at N+2 and valid_mod1 at N+4. Total latency is MAG_DLY+MIN_DLY+OUT_DLY.
- Gating: first and last outputs are 0 whenever their stage enable is 0.
- Ordering: the exact input gap pattern is reproduced at every stage. Back-to-back blocks are supported; out_last of block k may be immediately followed by out_first of block k+1.
- No stall or backpressure input exists. The downstream consumer must accept one sample per cycle.
- Structure: no FSM beyond the counter; all outputs are registered.

Optional Feature:
- Macro: CU_CBFP_BLKCNT_EN.
- Defined:
  - Port blk_cnt exists.
  - Increments by 1 in the cycle after valid_mod1 && out_last.
  - Wraps modulo 2^CNT_W.
  - Cleared by rst and by flush.
- Undefined: port blk_cnt and its counter are absent; all other behaviour is unchanged.

Test Plan:
- Defaults, BLK_LEN=4, single alert_cbfp pulse at cycle 10 -> mag_en=1 at 11 with mag_first=1; min_en=1 at 12; valid_mod1=1 at 14 with out_first=1; every other cycle all outputs 0.
- BLK_LEN=4, alert_cbfp high for 8 contiguous cycles from cycle 0 -> valid_mod1 high cycles 4-11; out_first at 4 and 8; out_last at 7 and 11; min_last at 5 and 9; blk_cnt=2 at cycle 12 (macro on).
- BLK_LEN=4, alert_cbfp pattern 1,0,1,1,0,0,1 -> valid_mod1 shows the same pattern delayed 4 cycles; out_last only on the 4th valid.
- flush asserted on the cycle of the 3rd sample of a block -> that sample is dropped; all outputs 0 next cycle; the next alert produces mag_first=1.
- BLK_LEN=1, MAG_DLY=2, MIN_DLY=3, OUT_DLY=1, three contiguous alerts -> mag_en at +2, min_en at +5, valid_mod1 at +6; first and last both 1 on every output sample.
- rst pulsed while 3 samples are in flight -> no enable asserts after reset; blk_cnt=0.
